// File: rtl/seq_div_8bit_if.sv
// Operand/result bundle for seq_div_8bit; div_by_zero exists only with DIV_ZERO_FLAG_EN.
// master drives start and operands, slave (the divider) returns results and status.
interface seq_div_8bit_if;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
`ifdef DIV_ZERO_FLAG_EN
   logic       div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
`else
   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done
   );
   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done
   );
`endif
endinterface

// File: rtl/seq_div_8bit.sv
// 8-bit unsigned restoring divider: 8 steps after accept, done pulses one cycle later, 10-cycle repeat.
// start is ignored while busy or done; DIV_ZERO_FLAG_EN adds a 1-cycle divide-by-zero bypass and flag.
module seq_div_8bit (
   input  logic        clk,
   input  logic        reset,
   seq_div_8bit_if.slave io
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] dvd_q;
   logic [7:0] dsr_q;
   logic [7:0] prem_q;
   logic [2:0] cnt_q;
   logic [7:0] quo_q;
   logic [7:0] rem_q;

   logic       accept;
   logic       step;
   logic       last_step;
   logic       busy_o;
   logic       done_o;
   logic       zero_bypass;

   logic [7:0] shift_lo;
   logic [8:0] diff;
   logic       qbit;
   logic [7:0] prem_nxt;

`ifdef DIV_ZERO_FLAG_EN
   logic       dbz_q;
   assign zero_bypass = (io.divisor == 8'd0);
`else
   assign zero_bypass = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (io.start) begin
               state_nxt = zero_bypass ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 3'd7) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept    = 1'b0;
      step      = 1'b0;
      last_step = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: accept = io.start;
         BUSY: begin
            busy_o    = 1'b1;
            step      = 1'b1;
            last_step = (cnt_q == 3'd7);
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   // Partial remainder is always below the divisor, so a 9-bit difference carries the sign in bit 8.
   assign shift_lo = {prem_q[6:0], dvd_q[7]};
   assign diff     = {prem_q, dvd_q[7]} - {1'b0, dsr_q};
   assign qbit     = ~diff[8];
   assign prem_nxt = qbit ? diff[7:0] : shift_lo;

   // Quotient bits fill the dividend register from the bottom as its top bits are consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dvd_q  <= 8'd0;
         dsr_q  <= 8'd0;
         prem_q <= 8'd0;
         cnt_q  <= 3'd0;
         quo_q  <= 8'd0;
         rem_q  <= 8'd0;
`ifdef DIV_ZERO_FLAG_EN
         dbz_q  <= 1'b0;
`endif
      end else if (accept) begin
         dvd_q  <= io.dividend;
         dsr_q  <= io.divisor;
         prem_q <= 8'd0;
         cnt_q  <= 3'd0;
`ifdef DIV_ZERO_FLAG_EN
         dbz_q  <= zero_bypass;
         if (zero_bypass) begin
            quo_q <= 8'hFF;
            rem_q <= io.dividend;
         end
`endif
      end else if (step) begin
         dvd_q  <= {dvd_q[6:0], qbit};
         prem_q <= prem_nxt;
         cnt_q  <= cnt_q + 3'd1;
         if (last_step) begin
            quo_q <= {dvd_q[6:0], qbit};
            rem_q <= prem_nxt;
         end
      end
   end

   assign io.quotient  = quo_q;
   assign io.remainder = rem_q;
   assign io.busy      = busy_o;
   assign io.done      = done_o;
`ifdef DIV_ZERO_FLAG_EN
   assign io.div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_seq_div_8bit.sv
// Directed and random checks of seq_div_8bit against a plain-arithmetic reference model.
module tb_seq_div_8bit;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   seq_div_8bit_if dif ();

   seq_div_8bit u_dut (
      .clk   (clk),
      .reset (reset),
      .io    (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_latency(input logic [7:0] b);
`ifdef DIV_ZERO_FLAG_EN
      return (b == 8'd0) ? 1 : 9;
`else
      return 9;
`endif
   endfunction

   function automatic int exp_busy(input logic [7:0] b);
`ifdef DIV_ZERO_FLAG_EN
      return (b == 8'd0) ? 0 : 8;
`else
      return 8;
`endif
   endfunction

   // One division from a start pulse; optionally pokes new operands and start while busy.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit interfere);
      logic [7:0] eq;
      logic [7:0] er;
      logic [7:0] prev_q;
      logic [7:0] prev_r;
      int         cycles;
      int         busy_cnt;
      bit         stable;
      eq = (b == 8'd0) ? 8'hFF : 8'(a / b);
      er = (b == 8'd0) ? a : 8'(a % b);
      @(negedge clk);
      prev_q       = dif.quotient;
      prev_r       = dif.remainder;
      dif.start    = 1'b1;
      dif.dividend = a;
      dif.divisor  = b;
      @(negedge clk);
      dif.start = 1'b0;
      cycles    = 1;
      busy_cnt  = 0;
      stable    = 1'b1;
      while (dif.done !== 1'b1 && cycles < 40) begin
         if (dif.busy === 1'b1) busy_cnt++;
         if (dif.quotient !== prev_q || dif.remainder !== prev_r) stable = 1'b0;
         if (interfere && cycles == 3) begin
            dif.start    = 1'b1;
            dif.dividend = 8'd50;
            dif.divisor  = 8'd5;
         end
         if (interfere && cycles == 5) dif.start = 1'b0;
         @(negedge clk);
         cycles++;
      end
      check("done_latency", cycles, exp_latency(b));
      check("busy_cycles", busy_cnt, exp_busy(b));
      check("outputs_held_while_busy", stable, 1);
      check($sformatf("quotient %0d/%0d", a, b), dif.quotient, eq);
      check($sformatf("remainder %0d/%0d", a, b), dif.remainder, er);
`ifdef DIV_ZERO_FLAG_EN
      check("div_by_zero", dif.div_by_zero, (b == 8'd0));
`endif
      @(negedge clk);
      check("done_one_cycle", dif.done, 0);
      check("busy_after_done", dif.busy, 0);
      check("quotient_hold", dif.quotient, eq);
      check("remainder_hold", dif.remainder, er);
   endtask

   initial begin
      int   t;
      int   last;
      int   pulses;
      bit   seen_done;
      logic [7:0] ra;
      logic [7:0] rb;

      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      dif.start    = 1'b0;
      dif.dividend = 8'd0;
      dif.divisor  = 8'd0;
      repeat (2) @(negedge clk);
      check("reset_quotient", dif.quotient, 0);
      check("reset_remainder", dif.remainder, 0);
      check("reset_busy", dif.busy, 0);
      check("reset_done", dif.done, 0);
`ifdef DIV_ZERO_FLAG_EN
      check("reset_div_by_zero", dif.div_by_zero, 0);
`endif
      reset = 1'b0;

      run_op(8'd100, 8'd7, 1'b0);
      run_op(8'd255, 8'd1, 1'b0);
      run_op(8'd5, 8'd9, 1'b0);
      run_op(8'd200, 8'd10, 1'b1);
      run_op(8'd77, 8'd0, 1'b0);
      run_op(8'd0, 8'd255, 1'b0);
      run_op(8'd255, 8'd255, 1'b0);

      // start held high: a new operation every 10 cycles
      @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = 8'd56;
      dif.divisor  = 8'd38;
      t      = 0;
      last   = -1;
      pulses = 0;
      while (pulses < 3 && t < 100) begin
         @(negedge clk);
         t++;
         if (dif.done === 1'b1) begin
            if (pulses == 0) check("b2b_first_latency", t, 9);
            else check("b2b_period", t - last, 10);
            check("b2b_quotient", dif.quotient, 1);
            check("b2b_remainder", dif.remainder, 18);
            last = t;
            pulses++;
         end
      end
      check("b2b_pulses", pulses, 3);
      dif.start = 1'b0;
      repeat (3) @(negedge clk);

      // reset in the middle of 250/3
      dif.start    = 1'b1;
      dif.dividend = 8'd250;
      dif.divisor  = 8'd3;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midreset_quotient", dif.quotient, 0);
      check("midreset_remainder", dif.remainder, 0);
      check("midreset_busy", dif.busy, 0);
      check("midreset_done", dif.done, 0);
      repeat (2) @(negedge clk);
      reset     = 1'b0;
      seen_done = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (dif.done === 1'b1) seen_done = 1'b1;
      end
      check("no_done_after_reset", seen_done, 0);
      check("idle_after_reset", dif.busy, 0);
      run_op(8'd250, 8'd3, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         run_op(ra, rb, ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
